// File: rtl/if_id_if.sv
// IF/ID stage bus: fetch-side valid/ready beat plus decode-side stall/flush and registered outputs.
// The slave modport is the stage itself; the master modport is the fetch/decode environment.
interface if_id_if #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int CNT_W  = 8
);
   logic [PC_W-1:0]   pc_i;
   logic [INST_W-1:0] inst_i;
   logic              valid_i;
   logic              ready_o;
   logic              stall_i;
   logic              flush_i;
   logic [PC_W-1:0]   pc_o;
   logic [INST_W-1:0] inst_o;
   logic              valid_o;
   logic [CNT_W-1:0]  hold_cnt_o;

   modport slave (
      input  pc_i, inst_i, valid_i, stall_i, flush_i,
      output ready_o, pc_o, inst_o, valid_o, hold_cnt_o
   );

   modport master (
      output pc_i, inst_i, valid_i, stall_i, flush_i,
      input  ready_o, pc_o, inst_o, valid_o, hold_cnt_o
   );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with bubble collapse, flush and a saturating stall-hold counter.
// Define IF_ID_SKID_EN to add a one-entry skid buffer so ready_o comes straight from a flop.
module if_id_stage #(
   parameter int                PC_W     = 32,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = '0,
   parameter int                CNT_W    = 8
) (
   input logic   clk_i,
   input logic   rst_i,
   if_id_if.slave bus
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic              vld_p1;
   logic [PC_W-1:0]   pc_p1;
   logic [INST_W-1:0] inst_p1;
   logic [CNT_W-1:0]  hold_p1;

   logic              adv;
   logic              rdy;
   logic              acc;
   logic              src_vld;
   logic [PC_W-1:0]   src_pc;
   logic [INST_W-1:0] src_inst;

   // A stalled stage whose output slot is empty still advances (bubble collapse).
   assign adv = !bus.stall_i || !vld_p1;
   assign acc = bus.valid_i && rdy;

`ifdef IF_ID_SKID_EN
   logic              skid_vld;
   logic [PC_W-1:0]   skid_pc;
   logic [INST_W-1:0] skid_inst;

   // While the skid is full rdy is low, so the skid and a fresh beat never compete.
   assign rdy      = !skid_vld;
   assign src_vld  = skid_vld || acc;
   assign src_pc   = skid_vld ? skid_pc   : bus.pc_i;
   assign src_inst = skid_vld ? skid_inst : bus.inst_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i || bus.flush_i || adv) begin
         skid_vld <= 1'b0;
      end else if (acc) begin
         skid_vld  <= 1'b1;
         skid_pc   <= bus.pc_i;
         skid_inst <= bus.inst_i;
      end
   end
`else
   assign rdy      = adv;
   assign src_vld  = acc;
   assign src_pc   = bus.pc_i;
   assign src_inst = bus.inst_i;
`endif

   // ---- IF -> ID register boundary ----
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         vld_p1  <= 1'b0;
         pc_p1   <= '0;
         inst_p1 <= NOP_INST;
         hold_p1 <= '0;
      end else if (bus.flush_i) begin
         vld_p1  <= 1'b0;
         inst_p1 <= NOP_INST;
         hold_p1 <= '0;
      end else if (adv) begin
         hold_p1 <= '0;
         if (src_vld) begin
            vld_p1  <= 1'b1;
            pc_p1   <= src_pc;
            inst_p1 <= src_inst;
         end else begin
            vld_p1  <= 1'b0;
            inst_p1 <= NOP_INST;
         end
      end else begin
         hold_p1 <= sat_inc(hold_p1);
      end
   end

   assign bus.ready_o    = rdy;
   assign bus.valid_o    = vld_p1;
   assign bus.pc_o       = pc_p1;
   assign bus.inst_o     = inst_p1;
   assign bus.hold_cnt_o = hold_p1;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized bench for if_id_stage with a queue-based reference model and directed literal checks.
module tb_if_id_stage;
   localparam int          PC_W    = 32;
   localparam int          INST_W  = 32;
   localparam int          CNT_W   = 2;
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        t_valid, t_stall, t_flush;
   logic [31:0] t_pc, t_inst;

   if_id_if #(.PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) bus ();

   assign bus.pc_i    = t_pc;
   assign bus.inst_i  = t_inst;
   assign bus.valid_i = t_valid;
   assign bus.stall_i = t_stall;
   assign bus.flush_i = t_flush;

   if_id_stage #(
      .PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP), .CNT_W(CNT_W)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_n),
      .bus  (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: what decode should see, plus beats parked while stalled.
   bit          m_vld;
   bit          m_pc_known;
   logic [31:0] m_pc, m_inst;
   int          m_cnt;
   logic [31:0] sk_pc[$];
   logic [31:0] sk_inst[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit m_ready();
`ifdef IF_ID_SKID_EN
      return sk_pc.size() == 0;
`else
      return !t_stall || !m_vld;
`endif
   endfunction

   task automatic m_edge();
      bit acc;
      acc = t_valid && m_ready();
      if (!rst_n) begin
         m_vld = 0; m_pc = 0; m_inst = NOP; m_cnt = 0; m_pc_known = 1;
         sk_pc.delete(); sk_inst.delete();
      end else if (t_flush) begin
         m_vld = 0; m_inst = NOP; m_cnt = 0;
         sk_pc.delete(); sk_inst.delete();
      end else if (!t_stall || !m_vld) begin
         m_cnt = 0;
         if (sk_pc.size() > 0) begin
            m_vld = 1; m_pc = sk_pc.pop_front(); m_inst = sk_inst.pop_front(); m_pc_known = 1;
         end else if (acc) begin
            m_vld = 1; m_pc = t_pc; m_inst = t_inst; m_pc_known = 1;
         end else begin
            m_vld = 0; m_inst = NOP; m_pc_known = 0;
         end
      end else begin
         m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
         if (acc) begin
            sk_pc.push_back(t_pc);
            sk_inst.push_back(t_inst);
         end
      end
   endtask

   // One clock: apply inputs, check ready_o, take the edge, then check registered outputs.
   task automatic cyc(input bit r, input bit v, input logic [31:0] p, input logic [31:0] i,
                      input bit s, input bit f);
      rst_n = r; t_valid = v; t_pc = p; t_inst = i; t_stall = s; t_flush = f;
      #1;
      chk("ready_o", {31'b0, bus.ready_o}, {31'b0, m_ready()});
      @(posedge clk);
      m_edge();
      #1;
      chk("valid_o", {31'b0, bus.valid_o}, {31'b0, m_vld});
      chk("inst_o", bus.inst_o, m_inst);
      chk("hold_cnt_o", {30'b0, bus.hold_cnt_o}, m_cnt);
      if (m_pc_known) chk("pc_o", bus.pc_o, m_pc);
   endtask

   function automatic logic [31:0] ins(input logic [31:0] p);
      return p ^ 32'hA5A5_0000;
   endfunction

   initial begin
      m_vld = 0; m_pc = 0; m_inst = NOP; m_cnt = 0; m_pc_known = 0;
      rst_n = 0; t_valid = 0; t_pc = 0; t_inst = 0; t_stall = 0; t_flush = 0;
      @(posedge clk); #1;

      // Reset held two cycles with a valid beat offered
      cyc(0, 1, 32'h40, ins(32'h40), 0, 0);
      cyc(0, 1, 32'h40, ins(32'h40), 0, 0);
      chk("rst valid_o", {31'b0, bus.valid_o}, 32'd0);
      chk("rst inst_o", bus.inst_o, NOP);
      chk("rst pc_o", bus.pc_o, 32'h0);
      chk("rst hold_cnt_o", {30'b0, bus.hold_cnt_o}, 32'd0);
      chk("rst ready_o", {31'b0, bus.ready_o}, 32'd1);

      // Streaming
      cyc(1, 1, 32'h100, ins(32'h100), 0, 0);
      chk("stream pc0", bus.pc_o, 32'h100);
      cyc(1, 1, 32'h104, ins(32'h104), 0, 0);
      chk("stream pc1", bus.pc_o, 32'h104);
      chk("stream vld1", {31'b0, bus.valid_o}, 32'd1);

      // Stall three cycles on 0x104 while 0x108 is offered
      cyc(1, 1, 32'h108, ins(32'h108), 1, 0);
      chk("stall cnt1", {30'b0, bus.hold_cnt_o}, 32'd1);
`ifdef IF_ID_SKID_EN
      #1 chk("skid ready low", {31'b0, bus.ready_o}, 32'd0);
`endif
      cyc(1, 1, 32'h108, ins(32'h108), 1, 0);
      cyc(1, 1, 32'h108, ins(32'h108), 1, 0);
      chk("stall cnt3", {30'b0, bus.hold_cnt_o}, 32'd3);
      chk("stall pc hold", bus.pc_o, 32'h104);
      chk("stall inst hold", bus.inst_o, ins(32'h104));
      cyc(1, 1, 32'h108, ins(32'h108), 0, 0);
      chk("release pc", bus.pc_o, 32'h108);
      chk("release cnt0", {30'b0, bus.hold_cnt_o}, 32'd0);
      cyc(1, 0, 32'h0, 32'h0, 0, 0);
      chk("drain vld", {31'b0, bus.valid_o}, 32'd0);
      chk("drain inst nop", bus.inst_o, NOP);

      // Five-cycle stall saturates the 2-bit counter
      cyc(1, 1, 32'h10C, ins(32'h10C), 0, 0);
      for (int k = 0; k < 5; k++) cyc(1, 0, 32'h0, 32'h0, 1, 0);
      chk("sat cnt", {30'b0, bus.hold_cnt_o}, 32'd3);
      cyc(1, 0, 32'h0, 32'h0, 0, 0);

      // Bubble collapse
      cyc(1, 1, 32'h200, ins(32'h200), 1, 0);
      chk("bubble vld", {31'b0, bus.valid_o}, 32'd1);
      chk("bubble pc", bus.pc_o, 32'h200);

      // Flush with stall, an incoming beat and (skid build) a parked beat
      cyc(1, 1, 32'h204, ins(32'h204), 1, 0);
      cyc(1, 1, 32'h208, ins(32'h208), 1, 1);
      chk("flush vld", {31'b0, bus.valid_o}, 32'd0);
      chk("flush inst", bus.inst_o, NOP);
      chk("flush pc", bus.pc_o, 32'h200);
      cyc(1, 0, 32'h0, 32'h0, 0, 0);
      chk("post flush empty", {31'b0, bus.valid_o}, 32'd0);

      // Reset in the middle of a stall
      cyc(1, 1, 32'h300, ins(32'h300), 0, 0);
      cyc(1, 1, 32'h304, ins(32'h304), 1, 0);
      cyc(0, 1, 32'h308, ins(32'h308), 1, 0);
      chk("midrst vld", {31'b0, bus.valid_o}, 32'd0);
      chk("midrst pc", bus.pc_o, 32'h0);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         logic [31:0] rp;
         rp = $urandom;
         cyc($urandom_range(0, 99) >= 2,
             $urandom_range(0, 99) < 60,
             rp, $urandom,
             $urandom_range(0, 99) < 40,
             $urandom_range(0, 99) < 8);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
